// File: rtl/fpu_pkg.sv
// Shared binary16 FPU definitions: field widths, special encodings, FSM states
// and operand unpacking. FPU_SUB_SUBNORMAL_EN selects gradual underflow;
// when it is undefined, subnormal inputs are flushed to signed zero.
package fpu_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned MANT_W   = FRAC_W + 1;   // with hidden bit
  localparam int unsigned WIDE_W   = MANT_W + 3;   // mantissa + G, R, S
  localparam int unsigned EXPR_W   = EXP_W + 1;    // room for exponent overflow
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned EXP_SUB  = EXP_MAX - 2 * EXP_BIAS;  // effective exponent of subnormals (1)

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_CALC,
    ST_NORM,
    ST_ROUND,
    ST_PACK
  } fpu_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              nan;
    logic              inf;
  } fpu_op_t;

  // Split a binary16 value into sign (optionally negated), effective exponent, significand and flags
  function automatic fpu_op_t fpu_unpack(input logic [15:0] x, input logic negate);
    fpu_op_t           op;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e       = x[14:10];
    f       = x[9:0];
    op.sign = x[15] ^ negate;
    op.nan  = (e == EXP_W'(EXP_MAX)) && (f != '0);
    op.inf  = (e == EXP_W'(EXP_MAX)) && (f == '0);
    if (e == '0) begin
      op.exp = EXP_W'(EXP_SUB);
`ifdef FPU_SUB_SUBNORMAL_EN
      op.mant = {1'b0, f};
`else
      op.mant = '0;
`endif
    end else begin
      op.exp  = e;
      op.mant = {1'b1, f};
    end
    return op;
  endfunction

endpackage

// File: rtl/fpu_subtractor_if.sv
// Request/response bundle between the peripheral register block and an FPU unit.
interface fpu_subtractor_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        valid_in;
  logic        busy;
  logic [15:0] result;
  logic        valid_out;

  modport master (output a, b, valid_in, input busy, result, valid_out);
  modport slave  (input a, b, valid_in, output busy, result, valid_out);
endinterface

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of an 11-bit significand with G/R/S; shared with the adder.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0] mant_in,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  input  logic [EXPR_W-1:0] exp_in,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXPR_W-1:0] exp_out,
  output logic              ovf
);

  logic            inc;
  logic [MANT_W:0] sum;

  // Increment on ties-to-even, renormalise a mantissa carry, flag exponent overflow
  always_comb begin
    inc = g & (r | s | mant_in[0]);
    sum = {1'b0, mant_in} + (MANT_W + 1)'(inc);
    if (sum[MANT_W]) begin
      mant_out = sum[MANT_W:1];
      exp_out  = exp_in + EXPR_W'(1);
    end else begin
      mant_out = sum[MANT_W-1:0];
      exp_out  = exp_in;
    end
    ovf = (exp_out >= EXPR_W'(EXP_MAX));
  end

endmodule

// File: rtl/fpu_subtractor.sv
// Multi-cycle binary16 a - b with RNE rounding and one-bit-per-cycle normalisation.
// FPU_SUB_SUBNORMAL_EN enables gradual underflow; otherwise flush-to-zero.
module fpu_subtractor
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fpu_subtractor_if.slave   bus
);

  fpu_state_e        state, state_d;
  logic [15:0]       a_q, b_q;
  fpu_op_t           op_a, op_b;
  logic              sign_r, eff_sub;
  logic [EXPR_W-1:0] exp_r;
  logic [WIDE_W-1:0] m_big, m_small;
  logic [WIDE_W:0]   m;
  logic [15:0]       arith_q;
  logic [15:0]       result_q, result_d;
  logic              valid_q, valid_d;

  logic              big_is_a, big_sign, sticky;
  logic [EXP_W-1:0]  big_exp, small_exp, diff;
  logic [MANT_W-1:0] big_mant, small_mant;
  logic [WIDE_W-1:0] wide, shifted, aligned;
  logic [WIDE_W:0]   sum_c;

  logic [MANT_W-1:0] rnd_mant;
  logic [EXPR_W-1:0] rnd_exp;
  logic              rnd_ovf;

  // Order operands by magnitude and right-align the smaller one with sticky collection
  always_comb begin
    big_is_a   = {op_a.exp, op_a.mant} >= {op_b.exp, op_b.mant};
    big_sign   = big_is_a ? op_a.sign : op_b.sign;
    big_exp    = big_is_a ? op_a.exp  : op_b.exp;
    big_mant   = big_is_a ? op_a.mant : op_b.mant;
    small_exp  = big_is_a ? op_b.exp  : op_a.exp;
    small_mant = big_is_a ? op_b.mant : op_a.mant;
    diff       = big_exp - small_exp;
    wide       = {small_mant, 3'b000};
    if (diff >= EXP_W'(WIDE_W)) begin
      shifted = '0;
      sticky  = |small_mant;
    end else begin
      shifted = wide >> diff;
      sticky  = |(wide & ((WIDE_W'(1) << diff) - WIDE_W'(1)));
    end
    aligned = {shifted[WIDE_W-1:1], shifted[0] | sticky};
  end

  // Magnitude add or subtract of the aligned significands
  always_comb begin
    if (eff_sub) sum_c = {1'b0, m_big} - {1'b0, m_small};
    else         sum_c = {1'b0, m_big} + {1'b0, m_small};
  end

  fpu_round_rne u_round (
    .mant_in  (m[WIDE_W-1:3]),
    .g        (m[2]),
    .r        (m[1]),
    .s        (m[0]),
    .exp_in   (exp_r),
    .mant_out (rnd_mant),
    .exp_out  (rnd_exp),
    .ovf      (rnd_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (bus.valid_in) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_CALC;
      ST_CALC:   state_d = (sum_c == '0) ? ST_ROUND : ST_NORM;
      ST_NORM: begin
        if (!m[WIDE_W] && !m[WIDE_W-1] && (exp_r > EXPR_W'(EXP_SUB))) state_d = ST_NORM;
        else                                                          state_d = ST_ROUND;
      end
      ST_ROUND:  state_d = ST_PACK;
      ST_PACK:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: specials override the arithmetic result in PACK
  always_comb begin
    valid_d  = (state == ST_PACK);
    result_d = result_q;
    if (state == ST_PACK) begin
      if (op_a.nan || op_b.nan || (op_a.inf && op_b.inf && (a_q[15] == b_q[15])))
        result_d = QNAN;
      else if (op_a.inf)
        result_d = a_q;
      else if (op_b.inf)
        result_d = POS_INF | {~b_q[15], 15'd0};
      else
        result_d = arith_q;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Datapath registers, one pipeline step per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sign_r  <= 1'b0;
      eff_sub <= 1'b0;
      exp_r   <= '0;
      m_big   <= '0;
      m_small <= '0;
      m       <= '0;
      arith_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.valid_in) begin
            a_q <= bus.a;
            b_q <= bus.b;
          end
        end
        ST_UNPACK: begin
          op_a <= fpu_unpack(a_q, 1'b0);
          op_b <= fpu_unpack(b_q, 1'b1);
        end
        ST_ALIGN: begin
          sign_r  <= big_sign;
          exp_r   <= EXPR_W'(big_exp);
          m_big   <= {big_mant, 3'b000};
          m_small <= aligned;
          eff_sub <= (op_a.sign != op_b.sign);
        end
        ST_CALC: begin
          if (sum_c == '0) begin
            m      <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
          end else begin
            m <= sum_c;
          end
        end
        ST_NORM: begin
          if (m[WIDE_W]) begin
            m     <= {1'b0, m[WIDE_W:2], m[1] | m[0]};
            exp_r <= exp_r + EXPR_W'(1);
          end else if (!m[WIDE_W-1] && (exp_r > EXPR_W'(EXP_SUB))) begin
            m     <= {m[WIDE_W-1:0], 1'b0};
            exp_r <= exp_r - EXPR_W'(1);
          end
        end
        ST_ROUND: begin
          if (!rnd_mant[MANT_W-1]) begin
`ifdef FPU_SUB_SUBNORMAL_EN
            arith_q <= {sign_r, EXP_W'(0), rnd_mant[FRAC_W-1:0]};
`else
            arith_q <= {sign_r, 15'd0};
`endif
          end else if (rnd_ovf || rnd_exp[EXP_W]) begin
            arith_q <= POS_INF | {sign_r, 15'd0};
          end else begin
            arith_q <= {sign_r, rnd_exp[EXP_W-1:0], rnd_mant[FRAC_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.result    = result_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_fpu_subtractor.sv
// Directed bench for fpu_subtractor: results, latency, specials, control behaviour.
module tb_fpu_subtractor;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fpu_subtractor_if bus ();

  fpu_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for valid_out; lat is the edge count after accept
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit in_cycle,
                        output int lat, output logic [15:0] res, output bit busy_ok);
    if (!in_cycle) @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    lat     = -1;
    res     = 'x;
    busy_ok = (bus.busy === 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out === 1'b1) begin
        lat     = k;
        res     = bus.result;
        busy_ok = busy_ok && (bus.busy === 1'b0);
        break;
      end
      busy_ok = busy_ok && (bus.busy === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", bus.result); end
    n_checks++;
    if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] res; bit bok;
    run_op(16'h4200, 16'h3C00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h4000) begin n_fail++; $display("FAIL basic_result got=%h exp=4000", res); end
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got=%0d exp=6", lat); end
    n_checks++;
    if (!bok) begin n_fail++; $display("FAIL basic_busy got=bad_profile exp=high_edges_0_to_5"); end
  endtask

  task automatic test_norm();
    int lat; logic [15:0] res; bit bok;
    run_op(16'h3C01, 16'h3C00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h1400) begin n_fail++; $display("FAIL norm10_result got=%h exp=1400", res); end
    n_checks++;
    if (lat !== 16) begin n_fail++; $display("FAIL norm10_latency got=%0d exp=16", lat); end
    run_op(16'h3C00, 16'h3C00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h0000) begin n_fail++; $display("FAIL zero_result got=%h exp=0000", res); end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL zero_latency got=%0d exp=5", lat); end
    run_op(16'h3C00, 16'h1001, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h3BFF) begin n_fail++; $display("FAIL rne_result got=%h exp=3bff", res); end
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL rne_latency got=%0d exp=7", lat); end
  endtask

  task automatic test_specials();
    int lat; logic [15:0] res; bit bok;
    run_op(16'h7C00, 16'h7C00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h7E00) begin n_fail++; $display("FAIL inf_minus_inf got=%h exp=7e00", res); end
    run_op(16'h7C00, 16'hFC00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h7C00) begin n_fail++; $display("FAIL inf_minus_neginf got=%h exp=7c00", res); end
    run_op(16'h3C00, 16'h7C00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'hFC00) begin n_fail++; $display("FAIL one_minus_inf got=%h exp=fc00", res); end
    run_op(16'h7C01, 16'h3C00, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h7E00) begin n_fail++; $display("FAIL nan_operand got=%h exp=7e00", res); end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] res; bit bok;
    run_op(16'h7BFF, 16'hFBFF, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== 16'h7C00) begin n_fail++; $display("FAIL overflow_result got=%h exp=7c00", res); end
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL overflow_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_subnormal();
    int lat; logic [15:0] res; bit bok; logic [15:0] exp_res;
`ifdef FPU_SUB_SUBNORMAL_EN
    exp_res = 16'h03FF;
`else
    exp_res = 16'h0400;
`endif
    run_op(16'h0400, 16'h0001, 1'b0, lat, res, bok);
    n_checks++;
    if (res !== exp_res) begin n_fail++; $display("FAIL subnormal_result got=%h exp=%h", res, exp_res); end
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL subnormal_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_drop_busy();
    int pulses; int first_edge; logic [15:0] res;
    pulses     = 0;
    first_edge = -1;
    res        = 'x;
    @(negedge clk);
    bus.a        = 16'h4200;
    bus.b        = 16'h3C00;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.a        = 16'h7C01;
      bus.b        = 16'h3C00;
      bus.valid_in = (k == 2) || (k == 4);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      if (bus.valid_out === 1'b1) begin
        pulses++;
        if (first_edge < 0) begin first_edge = k; res = bus.result; end
      end
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
    n_checks++;
    if (first_edge !== 6) begin n_fail++; $display("FAIL drop_latency got=%0d exp=6", first_edge); end
    n_checks++;
    if (res !== 16'h4000) begin n_fail++; $display("FAIL drop_result got=%h exp=4000", res); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.a        = 16'h3C01;
    bus.b        = 16'h3C00;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got=%h exp=0000", bus.result); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
    n_checks++;
    if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL midrst_hold got=%h exp=0000", bus.result); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [15:0] res1, res2; bit bok1, bok2;
    run_op(16'h4200, 16'h3C00, 1'b0, lat1, res1, bok1);
    run_op(16'h3C00, 16'h4200, 1'b1, lat2, res2, bok2);
    n_checks++;
    if (res1 !== 16'h4000) begin n_fail++; $display("FAIL b2b_first got=%h exp=4000", res1); end
    n_checks++;
    if (res2 !== 16'hC000) begin n_fail++; $display("FAIL b2b_second got=%h exp=c000", res2); end
    n_checks++;
    if (lat2 !== 6) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=6", lat2); end
    n_checks++;
    if (!bok2) begin n_fail++; $display("FAIL b2b_busy got=bad_profile exp=high_edges_0_to_5"); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_norm();
    test_specials();
    test_overflow();
    test_subnormal();
    test_drop_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
